// File: rtl/mov_pkg.sv
// Shared encodings for the MOV/shift slice: operation modes and FSM states.
package mov_pkg;

  localparam logic [1:0] MODE_MOV = 2'b00;
  localparam logic [1:0] MODE_SHL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mov_shift_step.sv
// Combinational single-bit step of the MOV/shift slice; MOV passes the word through.
module mov_shift_step
  import mov_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [1:0]      i_mode,
  input  logic [SIZE-1:0] i_w,
  output logic [SIZE-1:0] o_w_next
);

  always_comb begin
    o_w_next = i_w;
    case (i_mode)
      MODE_SHL: o_w_next = {i_w[SIZE-2:0], 1'b0};
      MODE_SHR: o_w_next = {1'b0, i_w[SIZE-1:1]};
      MODE_ROR: o_w_next = {i_w[0], i_w[SIZE-1:1]};
      default:  o_w_next = i_w;
    endcase
  end

endmodule

// File: rtl/mov_shift_unit.sv
// Registered MOV / SHL / SHR / ROR slice with start/busy/done handshake.
// Define MOV_SHIFT_FAST_EN for a single-cycle barrel-shifter build instead of the iterative engine.
module mov_shift_unit
  import mov_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] c,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(SIZE);

  // Handshake: start is sampled only while idle; done pulses for one cycle
  // with c freshly updated, and busy covers every non-idle cycle including done.
  state_t          r_state;
  logic [SIZE-1:0] r_c;
  logic            r_done;
  logic            w_unused_a;

  assign w_unused_a = ^a[SIZE-1:SHW];

`ifdef MOV_SHIFT_FAST_EN
  // Stage i holds b stepped i times; the amount selects the stage directly.
  logic [SIZE-1:0] w_chain [SIZE];

  assign w_chain[0] = b;

  for (genvar gi = 0; gi < SIZE - 1; gi++) begin : g_chain
    mov_shift_step #(.SIZE(SIZE)) u_step (
      .i_mode   (mode),
      .i_w      (w_chain[gi]),
      .o_w_next (w_chain[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_c     <= w_chain[a[SHW-1:0]];
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  logic [SIZE-1:0] r_w;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_mode;
  logic [SIZE-1:0] w_step;

  mov_shift_step #(.SIZE(SIZE)) u_step (
    .i_mode   (r_mode),
    .i_w      (r_w),
    .o_w_next (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_w     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_MOV;
      r_c     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_w    <= b;
            r_cnt  <= a[SHW-1:0];
            r_mode <= mode;
            // Nothing to shift: the result is b itself, published right away.
            if (mode == MODE_MOV || a[SHW-1:0] == '0) begin
              r_c     <= b;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_w   <= w_step;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_c     <= w_step;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`endif

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign c         = r_c;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mov_shift_unit.sv
// Directed self-checking bench for mov_shift_unit (SIZE=8), iterative or MOV_SHIFT_FAST_EN build.
module tb_mov_shift_unit;
  import mov_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_c;

  mov_shift_unit #(.SIZE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .c         (c),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int n);
`ifdef MOV_SHIFT_FAST_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  // Drives one start pulse; returns #1 after the sampling edge with inputs scrambled.
  task automatic drive_start(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    mode  = m;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
  endtask

  // Counts negedges until done is seen; lat = -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (c !== 8'h00) begin n_fail++; $display("FAIL reset_c got=%h exp=00", c); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    // Reset must win over a simultaneous start.
    start = 1'b1; mode = MODE_MOV; b = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_vs_start busy=%b done=%b exp=0/0", busy, done); end
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input logic [1:0] m, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [W-1:0] res, input int n);
    int lat;
    exp_q.push_back(res);
    drive_start(m, aa, bb);
    wait_done(lat);
    exp_c = exp_q.pop_front();
    n_cmp++; if (lat !== exp_lat(n)) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat(n)); end
    n_cmp++; if (c !== exp_c) begin n_fail++; $display("FAIL %s_c got=%h exp=%h", name, c, exp_c); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_in_done got=%b exp=1", name, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_after done=%b busy=%b exp=0/0", name, done, busy); end
    n_cmp++; if (c !== exp_c) begin n_fail++; $display("FAIL %s_c_held got=%h exp=%h", name, c, exp_c); end
  endtask

  task automatic test_shr_ignore();
    int lat;
    int extra;
    exp_q.push_back(8'h01);
    drive_start(MODE_SHR, 8'hF7, 8'h80);
    fork
      begin
`ifndef MOV_SHIFT_FAST_EN
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; mode = MODE_MOV; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
`endif
      end
      wait_done(lat);
    join
    exp_c = exp_q.pop_front();
    n_cmp++; if (lat !== exp_lat(7)) begin n_fail++; $display("FAIL shr7_latency got=%0d exp=%0d", lat, exp_lat(7)); end
    n_cmp++; if (c !== exp_c) begin n_fail++; $display("FAIL shr7_c got=%h exp=%h", c, exp_c); end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL shr7_no_second_done got=%0d exp=0", extra); end
    n_cmp++; if (c !== exp_c) begin n_fail++; $display("FAIL shr7_c_held got=%h exp=%h", c, exp_c); end
  endtask

  task automatic test_reset_mid();
    logic d1, d2;
    int   extra;
    drive_start(MODE_ROR, 8'h05, 8'hF0);
    @(negedge clk);
    d1 = done;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    d2 = done;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MOV_SHIFT_FAST_EN
    n_cmp++; if (d1 !== 1'b1) begin n_fail++; $display("FAIL rmid_done_t1 got=%b exp=1", d1); end
`else
    n_cmp++; if (d1 !== 1'b0) begin n_fail++; $display("FAIL rmid_done_t1 got=%b exp=0", d1); end
`endif
    n_cmp++; if (d2 !== 1'b0) begin n_fail++; $display("FAIL rmid_done_t2 got=%b exp=0", d2); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_cmp++; if (c !== 8'h00) begin n_fail++; $display("FAIL rmid_c got=%h exp=00", c); end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL rmid_no_done got=%0d exp=0", extra); end
    test_op("rmid_mov", MODE_MOV, 8'h00, 8'h11, 8'h11, 0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int period;
    @(negedge clk);
    mode = MODE_SHL; a = 8'h02; b = 8'h01; start = 1'b1;
    wait_done(lat);
    n_cmp++; if (c !== 8'h04) begin n_fail++; $display("FAIL b2b_c1 got=%h exp=04", c); end
    wait_done(period);
    start = 1'b0;
`ifdef MOV_SHIFT_FAST_EN
    n_cmp++; if (period !== 2) begin n_fail++; $display("FAIL b2b_period got=%0d exp=2", period); end
`else
    n_cmp++; if (period !== 4) begin n_fail++; $display("FAIL b2b_period got=%0d exp=4", period); end
`endif
    n_cmp++; if (c !== 8'h04) begin n_fail++; $display("FAIL b2b_c2 got=%h exp=04", c); end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_op("mov",  MODE_MOV, 8'hFF, 8'h5A, 8'h5A, 0);
    test_op("shl3", MODE_SHL, 8'h03, 8'h81, 8'h08, 3);
    test_op("ror1", MODE_ROR, 8'h01, 8'h81, 8'hC0, 1);
    test_shr_ignore();
    test_op("zero", MODE_SHR, 8'h08, 8'h3C, 8'h3C, 0);
    test_op("ror3", MODE_ROR, 8'h03, 8'hA5, 8'hB4, 3);
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
